// File: rtl/if_fetch_pkg.sv
// Shared constants, types and helpers for the MIPS instruction-fetch stage.
package if_fetch_pkg;
    localparam int          STALL_W       = 6;
    localparam int          IF_TO_ID_W    = 33;
    localparam int          BR_W          = 33;
    localparam int          IF_EXCP_W     = 33;
    localparam logic [31:0] RESET_VEC_DEF = 32'hBFC0_0000;
    localparam logic        STOP          = 1'b1;
    localparam logic        NO_STOP       = 1'b0;

    typedef enum logic {
        HOLD_PASS = 1'b0,
        HOLD_HELD = 1'b1
    } hold_state_e;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction
endpackage

// File: rtl/if_inst_hold.sv
// Keeps the word owned by decode stable while decode is stalled (PASS/HELD).
module if_inst_hold
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_id,
    input  logic [31:0] rdata,
    output logic [31:0] inst
);
    hold_state_e state_q;
    logic [31:0] hold_inst_q;

    // Capture the SRAM word on the first stalled edge; release when decode moves on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HOLD_PASS;
            hold_inst_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                HOLD_PASS: begin
                    if (stall_id == STOP) begin
                        state_q     <= HOLD_HELD;
                        hold_inst_q <= rdata;
                    end
                end
                HOLD_HELD: begin
                    if (stall_id == NO_STOP) begin
                        state_q <= HOLD_PASS;
                    end
                end
                default: state_q <= HOLD_PASS;
            endcase
        end
    end

    assign inst = (state_q == HOLD_HELD) ? hold_inst_q : rdata;
endmodule

// File: rtl/if_fetch.sv
// MIPS IF stage: PC register, SRAM request, branch redirect with pending latch.
// Optional misaligned-fetch detection is enabled with IF_ADDR_CHECK_EN.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic [BR_W-1:0]       br_bus,
    output logic [IF_TO_ID_W-1:0] if_to_id_bus,
    output logic                  inst_sram_en,
    output logic [3:0]            inst_sram_wen,
    output logic [31:0]           inst_sram_addr,
    output logic [31:0]           inst_sram_wdata,
    input  logic [31:0]           inst_sram_rdata,
    output logic [31:0]           if_inst,
    output logic [IF_EXCP_W-1:0]  if_excp_bus
);
    logic        br_e_s;
    logic [31:0] br_addr_s;
    logic [31:0] pc_q, pc_d;
    logic        ce_q;
    logic        br_pend_q;
    logic [31:0] br_pend_addr_q;
    logic [31:0] hold_inst_s;
    logic        adel_s;
    logic        unused_stall_s;

    assign {br_e_s, br_addr_s} = br_bus;
    assign unused_stall_s      = ^stall[STALL_W-1:2];

    always_comb begin
        if (br_e_s) begin
            pc_d = br_addr_s;
        end else if (br_pend_q) begin
            pc_d = br_pend_addr_q;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    // A redirect seen while IF is stalled must survive until the next advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q           <= RESET_VEC - 32'd4;
            ce_q           <= 1'b0;
            br_pend_q      <= 1'b0;
            br_pend_addr_q <= 32'h0000_0000;
        end else if (stall[0] == NO_STOP) begin
            pc_q      <= pc_d;
            ce_q      <= 1'b1;
            br_pend_q <= 1'b0;
        end else if (br_e_s) begin
            br_pend_q      <= 1'b1;
            br_pend_addr_q <= br_addr_s;
        end
    end

    if_inst_hold u_hold (
        .clk      (clk),
        .rst      (rst),
        .stall_id (stall[1]),
        .rdata    (inst_sram_rdata),
        .inst     (hold_inst_s)
    );

`ifdef IF_ADDR_CHECK_EN
    logic nop_q;

    assign adel_s = ce_q & pc_misaligned(pc_q);

    // The SRAM word returned after a faulting request is replaced by a nop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nop_q <= 1'b0;
        end else begin
            nop_q <= adel_s;
        end
    end

    assign if_excp_bus = (rst || !adel_s) ? 33'd0 : {1'b1, pc_q};
    assign if_inst     = (rst || nop_q) ? 32'h0000_0000 : hold_inst_s;
`else
    assign adel_s      = 1'b0;
    assign if_excp_bus = 33'd0;
    assign if_inst     = rst ? 32'h0000_0000 : hold_inst_s;
`endif

    // Outputs are forced low for the whole reset window.
    assign if_to_id_bus    = rst ? 33'd0 : {ce_q, pc_q};
    assign inst_sram_en    = rst ? 1'b0 : (ce_q & ~adel_s);
    assign inst_sram_addr  = rst ? 32'h0000_0000 : pc_q;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'h0000_0000;
endmodule
